// File: rtl/imm_gen_pipe.sv
// Immediate generator with target adder behind a 2-entry in-order skid buffer.
// Decode and add happen at accept; every output comes straight from a register.
module imm_gen_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_ins,
  input  logic [2:0]      in_sel,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_tgt,
  output logic [2:0]      out_sel,
  output logic            out_err
);

  if (XLEN != 32 && XLEN != 64) begin : g_xlen_chk
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  logic [1:0]      r_cnt;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [XLEN-1:0] r_out_imm;
  logic [XLEN-1:0] r_out_tgt;
  logic [2:0]      r_out_sel;
  logic            r_out_err;
  logic [XLEN-1:0] r_sk_imm;
  logic [XLEN-1:0] r_sk_tgt;
  logic [2:0]      r_sk_sel;
  logic            r_sk_err;

  logic [31:0]     w_raw;
  logic            w_sext;
  logic            w_err;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_tgt;
  logic            w_acc;
  logic            w_pop;
  logic [1:0]      w_cnt_nxt;
  logic            w_unused_ok;

  // Opcode bits play no part in immediate extraction.
  assign w_unused_ok = &{1'b0, in_ins[6:0]};

  always_comb begin
    w_raw  = '0;
    w_sext = 1'b1;
    w_err  = 1'b0;
    case (in_sel)
      3'b000: w_raw = {{20{in_ins[31]}}, in_ins[31:20]};
      3'b001: w_raw = {{20{in_ins[31]}}, in_ins[31:25], in_ins[11:7]};
      3'b010: w_raw = {{19{in_ins[31]}}, in_ins[31], in_ins[7], in_ins[30:25],
                       in_ins[11:8], 1'b0};
      3'b011: w_raw = {in_ins[31:12], 12'b0};
      3'b100: w_raw = {{11{in_ins[31]}}, in_ins[31], in_ins[19:12], in_ins[20],
                       in_ins[30:21], 1'b0};
      3'b101: begin
        w_sext = 1'b0;
        w_raw  = {27'b0, in_ins[19:15]};
      end
      3'b110: begin
        w_sext = 1'b0;
        w_raw  = (XLEN == 64) ? {26'b0, in_ins[25:20]} : {27'b0, in_ins[24:20]};
      end
      default: w_err = 1'b1;
    endcase
  end

  // The 32-bit raw value is already sign-correct; widen it for XLEN=64.
  assign w_imm = w_sext ? XLEN'($signed(w_raw)) : XLEN'(w_raw);
  assign w_tgt = in_pc + w_imm;

  assign w_acc = in_valid && r_in_ready;
  assign w_pop = r_out_valid && out_ready;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_acc && !w_pop)
      w_cnt_nxt = r_cnt + 2'd1;
    else if (!w_acc && w_pop)
      w_cnt_nxt = r_cnt - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_imm   <= '0;
      r_out_tgt   <= '0;
      r_out_sel   <= '0;
      r_out_err   <= 1'b0;
      r_sk_imm    <= '0;
      r_sk_tgt    <= '0;
      r_sk_sel    <= '0;
      r_sk_err    <= 1'b0;
    end else if (flush) begin
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_out_valid <= (w_cnt_nxt != 2'd0);
      r_in_ready  <= (w_cnt_nxt < 2'd2);
      // Output slot is the FIFO head; skid slot only holds the second entry.
      case (r_cnt)
        2'd0: begin
          if (w_acc) begin
            r_out_imm <= w_imm;
            r_out_tgt <= w_tgt;
            r_out_sel <= in_sel;
            r_out_err <= w_err;
          end
        end
        2'd1: begin
          if (w_acc && w_pop) begin
            r_out_imm <= w_imm;
            r_out_tgt <= w_tgt;
            r_out_sel <= in_sel;
            r_out_err <= w_err;
          end else if (w_acc) begin
            r_sk_imm <= w_imm;
            r_sk_tgt <= w_tgt;
            r_sk_sel <= in_sel;
            r_sk_err <= w_err;
          end
        end
        default: begin
          if (w_pop) begin
            r_out_imm <= r_sk_imm;
            r_out_tgt <= r_sk_tgt;
            r_out_sel <= r_sk_sel;
            r_out_err <= r_sk_err;
          end
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_imm   = r_out_imm;
  assign out_tgt   = r_out_tgt;
  assign out_sel   = r_out_sel;
  assign out_err   = r_out_err;

endmodule
